// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction controller: sequences fetch, decode, execute,
// memory, writeback, multi-cycle mult/div and exception states, and drives
// the PC/IR/regfile/dmem/HI-LO enables from the decoder's class flags.
module multicycle_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       imem_rdy,
    input  logic       dmem_rdy,
    input  logic       is_load,
    input  logic       is_store,
    input  logic       is_reg_wr,
    input  logic       is_muldiv,
    input  logic       is_div,
    input  logic       is_exc,
    output logic       imem_req,
    output logic       ir_ena,
    output logic       pc_ena,
    output logic       rf_wena,
    output logic       dmem_ena,
    output logic       dmem_wr,
    output logic       mdu_start,
    output logic       hilo_wena,
    output logic       exc_req,
    output logic [1:0] exc_cause,
    output logic       busy,
    output logic [2:0] state
);

    // Counters must hold the largest MDU preload and the timeout compare value.
    localparam int MAX_A = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int MAX_C = (MAX_A > MEM_TIMEOUT + 1) ? MAX_A : MEM_TIMEOUT + 1;
    localparam int CW    = (MAX_C < 2) ? 1 : $clog2(MAX_C + 1);

    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] TO_MAX  = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_MDU = 3'd5,
        S_EXC = 3'd6
    } state_t;

    state_t        st_q, st_d;
    logic [CW-1:0] mdu_cnt_q, mdu_cnt_d;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]    cause_q, cause_d;
    logic          start_q, start_d;

    // State, counters, sticky exception cause and the registered MDU start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= S_IF;
            mdu_cnt_q <= '0;
            to_cnt_q  <= '0;
            cause_q   <= 2'b00;
            start_q   <= 1'b0;
        end else begin
            st_q      <= st_d;
            mdu_cnt_q <= mdu_cnt_d;
            to_cnt_q  <= to_cnt_d;
            cause_q   <= cause_d;
            start_q   <= start_d;
        end
    end

    // Next-state and enable decode; start_d defaults low so mdu_start is a single pulse.
    always_comb begin
        st_d      = st_q;
        mdu_cnt_d = mdu_cnt_q;
        to_cnt_d  = to_cnt_q;
        cause_d   = cause_q;
        start_d   = 1'b0;
        imem_req  = 1'b0;
        ir_ena    = 1'b0;
        pc_ena    = 1'b0;
        rf_wena   = 1'b0;
        dmem_ena  = 1'b0;
        dmem_wr   = 1'b0;
        hilo_wena = 1'b0;
        exc_req   = 1'b0;
        busy      = 1'b0;
        case (st_q)
            S_IF: begin
                imem_req = 1'b1;
                ir_ena   = imem_rdy;
                if (imem_rdy) st_d = S_ID;
            end
            S_ID: begin
                // A trap outranks a mult/div so the MDU is never started for it.
                if (is_exc) begin
                    st_d    = S_EXC;
                    cause_d = 2'b01;
                end else if (is_muldiv) begin
                    st_d      = S_MDU;
                    mdu_cnt_d = is_div ? DIV_LD : MULT_LD;
                    start_d   = 1'b1;
                end else begin
                    st_d = S_EX;
                end
            end
            S_EX: begin
                if (is_load || is_store) begin
                    st_d     = S_MEM;
                    to_cnt_d = '0;
                end else if (is_reg_wr) begin
                    st_d = S_WB;
                end else begin
                    pc_ena = 1'b1;
                    st_d   = S_IF;
                end
            end
            S_MEM: begin
                dmem_ena = 1'b1;
                dmem_wr  = is_store;
                // Completion is checked first so a late ready still retires.
                if (dmem_rdy) begin
                    if (is_load) begin
                        st_d = S_WB;
                    end else begin
                        pc_ena = 1'b1;
                        st_d   = S_IF;
                    end
                end else if (to_cnt_q == TO_MAX) begin
                    st_d    = S_EXC;
                    cause_d = 2'b10;
                end else begin
                    to_cnt_d = to_cnt_q + ONE;
                end
            end
            S_WB: begin
                rf_wena = 1'b1;
                pc_ena  = 1'b1;
                st_d    = S_IF;
            end
            S_MDU: begin
                busy = 1'b1;
                if (mdu_cnt_q == '0) begin
                    hilo_wena = 1'b1;
                    pc_ena    = 1'b1;
                    st_d      = S_IF;
                end else begin
                    mdu_cnt_d = mdu_cnt_q - ONE;
                end
            end
            S_EXC: begin
                // PC update here loads the exception vector via the external PC mux.
                exc_req = 1'b1;
                pc_ena  = 1'b1;
                st_d    = S_IF;
            end
            default: st_d = S_IF;
        endcase
    end

    assign mdu_start = start_q;
    assign exc_cause = cause_q;
    assign state     = st_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each instruction scenario pushes its
// per-cycle stimulus and expected output vector; the runner pops and compares.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       imem_rdy = 1'b0, dmem_rdy = 1'b0;
    logic       is_load = 1'b0, is_store = 1'b0, is_reg_wr = 1'b0;
    logic       is_muldiv = 1'b0, is_div = 1'b0, is_exc = 1'b0;
    logic       imem_req, ir_ena, pc_ena, rf_wena, dmem_ena, dmem_wr;
    logic       mdu_start, hilo_wena, exc_req, busy;
    logic [1:0] exc_cause;
    logic [2:0] state;

    multicycle_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
        .is_load(is_load), .is_store(is_store), .is_reg_wr(is_reg_wr),
        .is_muldiv(is_muldiv), .is_div(is_div), .is_exc(is_exc),
        .imem_req(imem_req), .ir_ena(ir_ena), .pc_ena(pc_ena), .rf_wena(rf_wena),
        .dmem_ena(dmem_ena), .dmem_wr(dmem_wr), .mdu_start(mdu_start),
        .hilo_wena(hilo_wena), .exc_req(exc_req), .exc_cause(exc_cause),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rst, imem, dmem, ld, st, rw, md, dv, ex;
    } stim_t;

    // Flag bits for the expected-vector helper: {pc, rf, de, dw, ms, hl, er}.
    localparam logic [6:0] F_PC = 7'b1000000;
    localparam logic [6:0] F_RF = 7'b0100000;
    localparam logic [6:0] F_DE = 7'b0010000;
    localparam logic [6:0] F_DW = 7'b0001000;
    localparam logic [6:0] F_MS = 7'b0000100;
    localparam logic [6:0] F_HL = 7'b0000010;
    localparam logic [6:0] F_ER = 7'b0000001;
    localparam logic [6:0] F_NO = 7'b0000000;

    stim_t       stim_q[$];
    logic [14:0] exp_q[$];
    string       tag_q[$];
    stim_t       cls;
    string       cur;
    logic [1:0]  cause_m;
    int          n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (st,ireq,ir,pc,rf,de,dw,ms,hl,er,cause[2],busy)",
                     tag, got, exp);
        end
    endtask

    // Push one cycle: stimulus plus the full expected output vector.
    task automatic p(input logic [2:0] st, input logic im, input logic dm,
                     input logic rs, input logic [6:0] f);
        stim_t s;
        s = cls; s.rst = rs; s.imem = im; s.dmem = dm;
        stim_q.push_back(s);
        exp_q.push_back({st, (st == 3'd0), (st == 3'd0) & im, f[6:5], f[4:3],
                         f[2:1], f[0], cause_m, (st == 3'd5)});
        tag_q.push_back(cur);
    endtask

    task automatic set_cls(input string name, input logic ld, input logic st,
                           input logic rw, input logic md, input logic dv, input logic ex);
        cur = name;
        cls = '0;
        cls.ld = ld; cls.st = st; cls.rw = rw; cls.md = md; cls.dv = dv; cls.ex = ex;
    endtask

    task automatic fetch(input int waits);
        for (int i = 0; i < waits; i++) p(3'd0, 1'b0, 1'b0, 1'b0, F_NO);
        p(3'd0, 1'b1, 1'b0, 1'b0, F_NO);
        p(3'd1, 1'b0, 1'b0, 1'b0, F_NO);
    endtask

    task automatic alu(input int iw);
        set_cls("alu", 0, 0, 1, 0, 0, 0);
        fetch(iw);
        p(3'd2, 1'b0, 1'b0, 1'b0, F_NO);
        p(3'd4, 1'b0, 1'b0, 1'b0, F_PC | F_RF);
    endtask

    task automatic branch();
        set_cls("branch", 0, 0, 0, 0, 0, 0);
        fetch(0);
        p(3'd2, 1'b0, 1'b0, 1'b0, F_PC);
    endtask

    // waits = cycles in S_MEM without dmem_rdy before the completing cycle.
    task automatic mem_op(input string name, input logic is_st, input int waits);
        logic [6:0] wr;
        set_cls(name, !is_st, is_st, 0, 0, 0, 0);
        wr = is_st ? F_DW : F_NO;
        fetch(0);
        p(3'd2, 1'b0, 1'b0, 1'b0, F_NO);
        for (int i = 0; i < waits; i++) p(3'd3, 1'b0, 1'b0, 1'b0, F_DE | wr);
        if (is_st) begin
            p(3'd3, 1'b0, 1'b1, 1'b0, F_DE | wr | F_PC);
        end else begin
            p(3'd3, 1'b0, 1'b1, 1'b0, F_DE);
            p(3'd4, 1'b0, 1'b0, 1'b0, F_PC | F_RF);
        end
    endtask

    task automatic store_timeout();
        set_cls("st_tmo", 0, 1, 0, 0, 0, 0);
        fetch(0);
        p(3'd2, 1'b0, 1'b0, 1'b0, F_NO);
        for (int i = 0; i < 16; i++) p(3'd3, 1'b0, 1'b0, 1'b0, F_DE | F_DW);
        cause_m = 2'b10;
        p(3'd6, 1'b0, 1'b0, 1'b0, F_PC | F_ER);
    endtask

    task automatic muldiv(input logic dv, input int n);
        set_cls(dv ? "div" : "mult", 0, 0, 0, 1, dv, 0);
        fetch(0);
        for (int i = 0; i < n; i++)
            p(3'd5, 1'b0, 1'b0, 1'b0, ((i == 0) ? F_MS : F_NO) |
                                      ((i == n - 1) ? (F_HL | F_PC) : F_NO));
    endtask

    task automatic trap_md();
        set_cls("trap_md", 0, 0, 0, 1, 0, 1);
        fetch(0);
        cause_m = 2'b01;
        p(3'd6, 1'b0, 1'b0, 1'b0, F_PC | F_ER);
    endtask

    task automatic reset_cycle(input string name);
        cur = name;
        cause_m = 2'b00;
        p(3'd0, 1'b1, 1'b0, 1'b1, F_NO);
    endtask

    task automatic rst_in_mdu();
        set_cls("rst_mdu", 0, 0, 0, 1, 1, 0);
        fetch(0);
        p(3'd5, 1'b0, 1'b0, 1'b0, F_MS);
        for (int i = 0; i < 4; i++) p(3'd5, 1'b0, 1'b0, 1'b0, F_NO);
        reset_cycle("rst_mdu_rst");
    endtask

    initial begin
        stim_t       s;
        logic [14:0] e;
        string       t;
        cls = '0;
        cause_m = 2'b00;
        reset_cycle("reset");
        alu(0);
        alu(2);
        branch();
        mem_op("load_w3", 1'b0, 3);
        mem_op("store", 1'b1, 0);
        mem_op("load", 1'b0, 0);
        trap_md();
        store_timeout();
        mem_op("load_edge", 1'b0, 15);
        muldiv(1'b0, 4);
        muldiv(1'b1, 32);
        rst_in_mdu();
        alu(0);
        branch();

        while (stim_q.size() > 0) begin
            @(negedge clk);
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            rst = s.rst; imem_rdy = s.imem; dmem_rdy = s.dmem;
            is_load = s.ld; is_store = s.st; is_reg_wr = s.rw;
            is_muldiv = s.md; is_div = s.dv; is_exc = s.ex;
            #1;
            check(t, {17'b0, state, imem_req, ir_ena, pc_ena, rf_wena, dmem_ena,
                      dmem_wr, mdu_start, hilo_wena, exc_req, exc_cause, busy},
                  {17'b0, e});
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
